mop_issue_pipe: RTL and testbench

Parametrised micro-op issue and delay pipeline for the pairing datapath. It sits between the sequencer and the datapath units (preadder, L3-to-uint reduction, QPMM, cmul, postadder, write-back):
- accepts micro-ops over a valid/ready handshake;
- stalls issue on read-after-write hazards against in-flight writes;
- carries each op through a DEPTH-stage shift register and exposes configurable tap points plus the write-back port.

It replaces the fixed-length micro-op buffer. The sequencer must no longer pad schedules with NOPs to cover pipeline latency.

---
 rtl/mop_issue_pipe_pkg.sv | 46 ++++
 rtl/mop_scoreboard.sv | 34 +++
 rtl/mop_issue_pipe.sv | 139 +++++++++++++
 tb/tb_mop_issue_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mop_issue_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mop_issue_pipe_pkg
// Description : Shared constants and stage record for the micro-op issue pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package mop_issue_pipe_pkg;

    localparam int c_ADDR_W = 9;
    localparam int c_CTRL_W = 32;

    // Datapath unit latencies, in cycles
    localparam int c_LAT_READ    = 2;
    localparam int c_LAT_PREADD  = 1;
    localparam int c_LAT_UINT    = 4;
    localparam int c_LAT_QPMM    = 58;
    localparam int c_LAT_CMUL    = 1;
    localparam int c_LAT_POSTADD = 3;
    localparam int c_LAT_WRITE   = 2;

    localparam int c_DEPTH = c_LAT_READ + c_LAT_PREADD + c_LAT_UINT + c_LAT_QPMM
                           + c_LAT_CMUL + c_LAT_POSTADD + c_LAT_WRITE + 1;
    // RAM write port is driven from the first write stage
    localparam int c_WR_STAGE = c_DEPTH - c_LAT_WRITE;

    localparam int c_N_TAPS      = 5;
    localparam int c_TAP_PREADD  = c_LAT_READ;
    localparam int c_TAP_UINT    = c_TAP_PREADD + c_LAT_PREADD;
    localparam int c_TAP_QPMM    = c_TAP_UINT + c_LAT_UINT;
    localparam int c_TAP_CMUL    = c_TAP_QPMM + c_LAT_QPMM;
    localparam int c_TAP_POSTADD = c_TAP_CMUL + c_LAT_CMUL;

    localparam logic [c_N_TAPS*8-1:0] c_TAP_POS = {
        8'(c_TAP_POSTADD), 8'(c_TAP_CMUL), 8'(c_TAP_QPMM),
        8'(c_TAP_UINT), 8'(c_TAP_PREADD)
    };

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [c_ADDR_W-1:0] dst;
        logic [c_CTRL_W-1:0] ctrl;
    } mop_stage_t;

endpackage
`default_nettype wire

// File: rtl/mop_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : mop_scoreboard
// Description : Parallel RAW comparators of the offered sources against
//               uncommitted in-flight destinations.
// Revision    : 1.0 - initial release
// ============================================================================
module mop_scoreboard #(
    parameter int ADDR_W   = 9,
    parameter int N_STAGES = 71
) (
    input  logic                         i_valid,
    input  logic [1:0]                   i_rd,
    input  logic [ADDR_W-1:0]            i_src0,
    input  logic [ADDR_W-1:0]            i_src1,
    input  logic [N_STAGES-1:0]          i_stage_vwe,
    input  logic [N_STAGES*ADDR_W-1:0]   i_stage_dst,
    output logic                         o_hazard
);

    logic [N_STAGES-1:0] w_match;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_cmp
        logic [ADDR_W-1:0] w_dst;
        assign w_dst      = i_stage_dst[k*ADDR_W +: ADDR_W];
        assign w_match[k] = i_stage_vwe[k] &
                            ((i_rd[0] & (i_src0 == w_dst)) |
                             (i_rd[1] & (i_src1 == w_dst)));
    end

    assign o_hazard = i_valid & (|w_match);

endmodule
`default_nettype wire

// File: rtl/mop_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mop_issue_pipe
// Description : Micro-op issue with RAW stall, DEPTH-stage delay line,
//               control taps, write-back port and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mop_issue_pipe
    import mop_issue_pipe_pkg::*;
#(
    parameter int                  ADDR_W   = c_ADDR_W,
    parameter int                  CTRL_W   = c_CTRL_W,
    parameter int                  DEPTH    = c_DEPTH,
    parameter int                  WR_STAGE = c_WR_STAGE,
    parameter int                  N_TAPS   = c_N_TAPS,
    parameter logic [N_TAPS*8-1:0] TAP_POS  = c_TAP_POS,
    parameter int                  CNT_W    = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       clr_cnt,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_src0,
    input  logic [ADDR_W-1:0]          in_src1,
    input  logic [1:0]                 in_rd,
    input  logic [ADDR_W-1:0]          in_dst,
    input  logic                       in_we,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic [N_TAPS-1:0]          tap_valid,
    output logic [N_TAPS*CTRL_W-1:0]   tap_ctrl,
    output logic [N_TAPS*ADDR_W-1:0]   tap_dst,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       busy,
    output logic                       hazard,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] dst;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    stage_t r_stage [DEPTH];

    logic                           w_hazard;
    logic                           w_ready;
    logic                           w_accept;
    logic [DEPTH-1:0]               w_valid_vec;
    logic [WR_STAGE:0]              w_sb_vwe;
    logic [(WR_STAGE+1)*ADDR_W-1:0] w_sb_dst;
    logic [CNT_W-1:0]               r_cycle_cnt;
    logic [CNT_W-1:0]               r_stall_cnt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_vvec
        assign w_valid_vec[k] = r_stage[k].valid;
    end

    // Stages past WR_STAGE have committed and no longer block readers
    for (genvar k = 0; k <= WR_STAGE; k++) begin : g_sb
        assign w_sb_vwe[k]                 = r_stage[k].valid & r_stage[k].we;
        assign w_sb_dst[k*ADDR_W +: ADDR_W] = r_stage[k].dst;
    end

    mop_scoreboard #(
        .ADDR_W   (ADDR_W),
        .N_STAGES (WR_STAGE + 1)
    ) u_scoreboard (
        .i_valid     (in_valid),
        .i_rd        (in_rd),
        .i_src0      (in_src0),
        .i_src1      (in_src1),
        .i_stage_vwe (w_sb_vwe),
        .i_stage_dst (w_sb_dst),
        .o_hazard    (w_hazard)
    );

    assign w_ready  = ~w_hazard & ~flush;
    assign w_accept = in_valid & w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_stage[0] <= '{valid: 1'b1, we: in_we, dst: in_dst, ctrl: in_ctrl};
            end else begin
                r_stage[0] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
                if (flush) begin
                    r_stage[k].valid <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
        localparam int c_POS = int'(TAP_POS[i*8 +: 8]);
        assign tap_valid[i]                = r_stage[c_POS].valid;
        assign tap_ctrl[i*CTRL_W +: CTRL_W] = r_stage[c_POS].valid ? r_stage[c_POS].ctrl : '0;
        assign tap_dst[i*ADDR_W +: ADDR_W]  = r_stage[c_POS].dst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((busy | in_valid) && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if ((in_valid & ~w_ready) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_ready;
    assign hazard    = w_hazard;
    assign busy      = |w_valid_vec;
    assign wr_en     = r_stage[WR_STAGE].valid & r_stage[WR_STAGE].we & ~flush;
    assign wr_addr   = r_stage[WR_STAGE].dst;
    assign cycle_cnt = r_cycle_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mop_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mop_issue_pipe
// Description : Self-checking bench: directed vectors, corner sequences and
//               randomized traffic against a time-indexed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mop_issue_pipe;

    localparam int AW    = 9;
    localparam int CW    = 32;
    localparam int DEPTH = 72;
    localparam int WR    = 70;
    localparam int NT    = 5;
    localparam int CNTW  = 24;
    localparam logic [NT*8-1:0] TAPS = {8'd66, 8'd65, 8'd7, 8'd3, 8'd2};

    int tap_pos [NT] = '{2, 3, 7, 65, 66};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            clr_cnt = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_we = 1'b0;
    logic [AW-1:0]   in_src0 = '0;
    logic [AW-1:0]   in_src1 = '0;
    logic [AW-1:0]   in_dst = '0;
    logic [1:0]      in_rd = '0;
    logic [CW-1:0]   in_ctrl = '0;
    logic            in_ready, wr_en, busy, hazard;
    logic [NT-1:0]   tap_valid;
    logic [NT*CW-1:0] tap_ctrl;
    logic [NT*AW-1:0] tap_dst;
    logic [AW-1:0]   wr_addr;
    logic [CNTW-1:0] cycle_cnt, stall_cnt;

    logic            s_valid = 1'b0;
    logic            s_clr = 1'b0;
    logic            s_ready, s_wr_en, s_busy, s_hazard;
    logic [NT-1:0]   s_tap_valid;
    logic [NT*CW-1:0] s_tap_ctrl;
    logic [NT*AW-1:0] s_tap_dst;
    logic [AW-1:0]   s_wr_addr;
    logic [3:0]      s_cyc, s_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mop_issue_pipe #(
        .ADDR_W(AW), .CTRL_W(CW), .DEPTH(DEPTH), .WR_STAGE(WR),
        .N_TAPS(NT), .TAP_POS(TAPS), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_src0(in_src0),
        .in_src1(in_src1), .in_rd(in_rd), .in_dst(in_dst), .in_we(in_we),
        .in_ctrl(in_ctrl), .tap_valid(tap_valid), .tap_ctrl(tap_ctrl),
        .tap_dst(tap_dst), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy),
        .hazard(hazard), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    mop_issue_pipe #(
        .ADDR_W(AW), .CTRL_W(CW), .DEPTH(DEPTH), .WR_STAGE(WR),
        .N_TAPS(NT), .TAP_POS(TAPS), .CNT_W(4)
    ) dut_s (
        .clk(clk), .rst(rst), .flush(1'b0), .clr_cnt(s_clr),
        .in_valid(s_valid), .in_ready(s_ready), .in_src0(9'd0),
        .in_src1(9'd0), .in_rd(2'b00), .in_dst(9'd0), .in_we(1'b1),
        .in_ctrl(32'd0), .tap_valid(s_tap_valid), .tap_ctrl(s_tap_ctrl),
        .tap_dst(s_tap_dst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .busy(s_busy),
        .hazard(s_hazard), .cycle_cnt(s_cyc), .stall_cnt(s_stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_we = 1'b0; in_rd = 2'b00; flush = 1'b0; clr_cnt = 1'b0;
        in_src0 = '0; in_src1 = '0; in_dst = '0; in_ctrl = '0;
        s_valid = 1'b0; s_clr = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic offer(input int dst, input int s0, input int s1, input logic [1:0] rd, input logic we);
        in_valid = 1'b1; in_we = we; in_rd = rd;
        in_dst = AW'(dst); in_src0 = AW'(s0); in_src1 = AW'(s1); in_ctrl = CW'(dst + 32'h1000);
    endtask

    typedef struct {
        logic          a_we;
        logic [1:0]    rd;
        logic [AW-1:0] s0;
        logic [AW-1:0] s1;
        int            exp_acc;
    } vec_t;

    typedef struct {
        int            tc;
        logic          we;
        logic [AW-1:0] dst;
        logic [CW-1:0] ctrl;
    } mop_t;

    initial begin
        vec_t vt [8];
        mop_t q [$];
        int   acc, seen, s;
        logic exp_wr, m_haz, m_busy, m_wr, m_rdy;
        logic [AW-1:0] m_wa;
        logic [NT-1:0] m_tv;
        logic [NT*CW-1:0] m_tc;
        logic [NT*AW-1:0] m_td;
        longint unsigned m_cyc, m_stall;

        vt[0] = '{1'b1, 2'b01, 9'd5, 9'd0, 72};
        vt[1] = '{1'b1, 2'b00, 9'd5, 9'd5, 1};
        vt[2] = '{1'b1, 2'b10, 9'd0, 9'd5, 72};
        vt[3] = '{1'b1, 2'b10, 9'd5, 9'd3, 1};
        vt[4] = '{1'b1, 2'b01, 9'd6, 9'd5, 1};
        vt[5] = '{1'b0, 2'b11, 9'd5, 9'd5, 1};
        vt[6] = '{1'b1, 2'b11, 9'd5, 9'd5, 72};
        vt[7] = '{1'b1, 2'b01, 9'd9, 9'd9, 1};

        // Reset state
        do_reset();
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_tap_valid", tap_valid, 0);
        chk("rst_tap_ctrl", tap_ctrl[63:0], 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Directed RAW vectors: A (dst=5) in cycle 0, B (dst=9) offered from cycle 1
        for (int v = 0; v < 8; v++) begin
            do_reset();
            offer(5, 100, 101, 2'b00, vt[v].a_we);
            nxt();
            in_valid = 1'b1; in_we = 1'b1; in_dst = 9'd9; in_rd = vt[v].rd;
            in_src0 = vt[v].s0; in_src1 = vt[v].s1;
            acc = -1;
            for (int c = 1; c < 200 && acc < 0; c++) begin
                #1;
                if (in_ready) acc = c;
                nxt();
            end
            idle();
            chk($sformatf("vec%0d_accept_cycle", v), acc, vt[v].exp_acc);
            chk($sformatf("vec%0d_stall_cnt", v), stall_cnt, vt[v].exp_acc - 1);
        end

        // Independent back-to-back ops
        do_reset();
        for (int c = 0; c < 180; c++) begin
            if (c < 100) offer(c, 200 + c, 300 + c, 2'b11, 1'b1);
            else idle();
            #1;
            if (c < 100) chk("indep_ready", in_ready, 1);
            exp_wr = (c >= 71) && (c < 171);
            chk("indep_wr_en", wr_en, exp_wr);
            if (exp_wr) chk("indep_wr_addr", wr_addr, c - 71);
            nxt();
        end
        chk("indep_stall_cnt", stall_cnt, 0);
        chk("indep_cycle_cnt", cycle_cnt, 172);

        // Flush with 10 ops in flight
        do_reset();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) offer(10 + c, 200 + c, 300 + c, 2'b11, 1'b1);
            else idle();
            nxt();
        end
        offer(50, 400, 401, 2'b11, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_ready", in_ready, 0);
        chk("flush_wr_en", wr_en, 0);
        nxt();
        idle();
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_tap_valid", tap_valid, 0);
        for (int c = 0; c < 100; c++) begin
            if (wr_en) seen++;
            nxt();
        end
        chk("flush_no_wr", seen, 0);

        // Asynchronous reset mid-stream
        do_reset();
        for (int c = 0; c < 30; c++) begin
            offer(c, 200 + c, 300 + c, 2'b11, 1'b1);
            nxt();
        end
        offer(30, 230, 330, 2'b11, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", in_ready, 1);
        chk("arst_tap_valid", tap_valid, 0);
        chk("arst_tap_ctrl", tap_ctrl[63:0], 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_hazard", hazard, 0);
        chk("arst_cycle_cnt", cycle_cnt, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        idle();
        nxt();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 90; c++) begin
            if (wr_en || busy) seen++;
            nxt();
        end
        chk("arst_no_activity", seen, 0);

        // Counter saturation and clear on a 4-bit instance
        do_reset();
        s_valid = 1'b1;
        repeat (20) nxt();
        chk("sat_cycle_cnt", s_cyc, 15);
        chk("sat_stall_cnt", s_stall, 0);
        s_clr = 1'b1;
        nxt();
        s_clr = 1'b0;
        chk("sat_clr", s_cyc, 0);
        nxt();
        chk("sat_after_clr", s_cyc, 1);
        s_valid = 1'b0;

        // Randomized traffic against a time-indexed reference model
        do_reset();
        q.delete();
        m_cyc = 0;
        m_stall = 0;
        for (int t = 0; t < 1500; t++) begin
            while (q.size() > 0 && (t - q[0].tc - 1) >= DEPTH) void'(q.pop_front());
            in_valid = ($urandom_range(0, 9) < 7);
            in_we    = ($urandom_range(0, 4) != 0);
            in_dst   = AW'($urandom_range(0, 31));
            in_src0  = AW'($urandom_range(0, 31));
            in_src1  = AW'($urandom_range(0, 31));
            in_rd    = 2'($urandom_range(0, 3));
            in_ctrl  = $urandom;
            flush    = ($urandom_range(0, 99) == 0);
            clr_cnt  = ($urandom_range(0, 149) == 0);

            m_haz = 1'b0; m_busy = (q.size() > 0); m_wr = 1'b0; m_wa = '0;
            m_tv = '0; m_tc = '0; m_td = '0;
            foreach (q[j]) begin
                s = t - q[j].tc - 1;
                if (in_valid && q[j].we && s <= WR &&
                    ((in_rd[0] && in_src0 == q[j].dst) || (in_rd[1] && in_src1 == q[j].dst)))
                    m_haz = 1'b1;
                if (s == WR && q[j].we && !flush) begin
                    m_wr = 1'b1;
                    m_wa = q[j].dst;
                end
                for (int i = 0; i < NT; i++) begin
                    if (s == tap_pos[i]) begin
                        m_tv[i] = 1'b1;
                        m_tc[i*CW +: CW] = q[j].ctrl;
                        m_td[i*AW +: AW] = q[j].dst;
                    end
                end
            end
            m_rdy = !m_haz && !flush;

            #1;
            chk("rnd_ready", in_ready, m_rdy);
            chk("rnd_hazard", hazard, m_haz);
            chk("rnd_wr_en", wr_en, m_wr);
            if (m_wr) chk("rnd_wr_addr", wr_addr, m_wa);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_tap_valid", tap_valid, m_tv);
            for (int i = 0; i < NT; i++) begin
                chk("rnd_tap_ctrl", tap_ctrl[i*CW +: CW], m_tc[i*CW +: CW]);
                if (m_tv[i]) chk("rnd_tap_dst", tap_dst[i*AW +: AW], m_td[i*AW +: AW]);
            end

            nxt();
            if (flush) q.delete();
            if (in_valid && m_rdy) q.push_back('{t, in_we, in_dst, in_ctrl});
            if (clr_cnt) begin
                m_cyc = 0;
                m_stall = 0;
            end else begin
                if ((m_busy || in_valid) && m_cyc < 64'hFFFFFF) m_cyc++;
                if (in_valid && !m_rdy && m_stall < 64'hFFFFFF) m_stall++;
            end
            chk("rnd_cycle_cnt", cycle_cnt, m_cyc);
            chk("rnd_stall_cnt", stall_cnt, m_stall);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
